// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the memory port arbiter and its ID FIFO.
package mem_port_arbiter_pkg;

   localparam bit CMD_READ  = 1'b0;
   localparam bit CMD_WRITE = 1'b1;

   localparam int DEF_NUM_PORTS       = 2;
   localparam int DEF_ADDR_WIDTH      = 32;
   localparam int DEF_DATA_WIDTH      = 32;
   localparam int DEF_MAX_OUTSTANDING = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Index width that never collapses to zero bits
   function automatic int idw(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter. master = arbiter view,
// slave = the environment (requesters plus downstream memory).
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = DEF_NUM_PORTS,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic [NUM_PORTS-1:0]                 req_start;
   logic [NUM_PORTS-1:0]                 req_write;
   logic [NUM_PORTS-1:0]                 req_ready;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wmask;
   logic [DATA_WIDTH-1:0]                resp_rdata;
   logic [NUM_PORTS-1:0]                 resp_valid;
   logic                                 mem_cmd_start;
   logic                                 mem_cmd_write;
   logic                                 mem_cmd_ready;
   logic [ADDR_WIDTH-1:0]                mem_addr;
   logic [DATA_WIDTH-1:0]                mem_wdata;
   logic [DATA_WIDTH-1:0]                mem_wmask;
   logic [DATA_WIDTH-1:0]                mem_rdata;
   logic                                 mem_rdata_valid;

   modport master (
      input  req_start, req_write, req_addr, req_wdata, req_wmask,
      input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
      output req_ready, resp_rdata, resp_valid,
      output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask
   );

   modport slave (
      output req_start, req_write, req_addr, req_wdata, req_wmask,
      output mem_cmd_ready, mem_rdata, mem_rdata_valid,
      input  req_ready, resp_rdata, resp_valid,
      input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/mem_port_arbiter_id_fifo.sv
// Port-ID FIFO: remembers which port issued each outstanding read so that
// in-order responses can be steered back.
module mem_arb_id_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_id,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PTRW = idw(DEPTH);
   localparam int CNTW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  wr_ptr, rd_ptr;
   logic [CNTW-1:0]  count;
   logic             do_push, do_pop;

   assign full    = (count == CNTW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Explicit wrap keeps DEPTH=1 legal with a 1-bit pointer
   function automatic logic [PTRW-1:0] nxt(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop)  rd_ptr <= nxt(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port start/ready command arbiter onto one memory port with in-order read
// response routing. Optional checks/trace: MEM_PORT_ARBITER_DEBUG_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS       = DEF_NUM_PORTS,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int ROUND_ROBIN     = 1
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);
   localparam int PW = idw(NUM_PORTS);

   logic [NUM_PORTS-1:0] cand;
   logic [PW-1:0]        g, rr_ptr, lock_port, head;
   logic                 lock_vld, any_cand, cmd_start, xfer;
   logic                 push, pop, fifo_full, fifo_empty;

   // Reads are held off while every ID slot is in use; writes never are
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++)
         cand[i] = bus.req_start[i] && !(bus.req_write[i] == CMD_READ && fifo_full);
   end

   always_comb begin
      int s;
      s        = 0;
      g        = '0;
      any_cand = |cand;
      // Scan downward so the nearest candidate is assigned last
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (ROUND_ROBIN != 0) begin
            s = int'(rr_ptr) + k;
            if (s >= NUM_PORTS) s = s - NUM_PORTS;
         end else begin
            s = k;
         end
         if (cand[s]) g = PW'(s);
      end
      if (lock_vld) g = lock_port;
   end

   assign cmd_start = !rst && (any_cand || lock_vld);
   assign xfer      = cmd_start && bus.mem_cmd_ready;
   assign push      = xfer && (bus.req_write[g] == CMD_READ);
   assign pop       = !rst && bus.mem_rdata_valid && !fifo_empty;

   assign bus.mem_cmd_start = cmd_start;
   assign bus.mem_cmd_write = cmd_start ? bus.req_write[g] : 1'b0;
   assign bus.mem_addr      = cmd_start ? bus.req_addr[g]  : {ADDR_WIDTH{1'b0}};
   assign bus.mem_wdata     = cmd_start ? bus.req_wdata[g] : {DATA_WIDTH{1'b0}};
   assign bus.mem_wmask     = cmd_start ? bus.req_wmask[g] : {DATA_WIDTH{1'b0}};
   assign bus.resp_rdata    = pop ? bus.mem_rdata : {DATA_WIDTH{1'b0}};

   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      if (xfer) bus.req_ready[g]     = 1'b1;
      if (pop)  bus.resp_valid[head] = 1'b1;
   end

   // A stalled grant is pinned until it transfers so the command stays stable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         lock_vld  <= 1'b0;
         lock_port <= '0;
      end else if (xfer) begin
         lock_vld <= 1'b0;
         rr_ptr   <= (g == PW'(NUM_PORTS - 1)) ? '0 : g + 1'b1;
      end else if (cmd_start) begin
         lock_vld  <= 1'b1;
         lock_port <= g;
      end
   end

   mem_arb_id_fifo #(
      .WIDTH (PW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .push_id (g),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (head)
   );

`ifdef MEM_PORT_ARBITER_DEBUG_EN
   logic [ADDR_WIDTH-1:0] dbg_lock_addr;

   always @(posedge clk) begin
      if (!rst) begin
         if (xfer)
            $display("mem_port_arbiter: port %0d %s addr 0x%h", g,
                     bus.req_write[g] ? "W" : "R", bus.req_addr[g]);
         if (bus.mem_rdata_valid && fifo_empty)
            $error("mem_port_arbiter: stray read response");
         if (lock_vld && (!bus.req_start[lock_port] || bus.req_addr[lock_port] != dbg_lock_addr))
            $error("mem_port_arbiter: locked port %0d changed command before ready", lock_port);
         if (cmd_start && !xfer && !lock_vld)
            dbg_lock_addr <= bus.req_addr[g];
      end
   end
`else
   // Trace and protocol checks are compiled out in this build
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: fixed-priority vector table plus round-robin corner sequences.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) if_rr ();
   mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) if_fx ();

   mem_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                      .MAX_OUTSTANDING(4), .ROUND_ROBIN(1))
      u_rr (.clk(clk), .rst(rst), .bus(if_rr));

   mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                      .MAX_OUTSTANDING(2), .ROUND_ROBIN(0))
      u_fx (.clk(clk), .rst(rst), .bus(if_fx));

   typedef struct {
      logic [1:0]  start, write;
      logic        rdy, rv;
      logic [1:0]  e_ready;
      logic        e_start, e_write;
      logic [31:0] e_addr;
      logic [1:0]  e_resp;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clr_inputs;
      if_rr.req_start = '0; if_rr.req_write = '0;
      if_rr.req_wdata = '0; if_rr.req_wmask = '0;
      if_rr.mem_cmd_ready = 1'b0; if_rr.mem_rdata = '0; if_rr.mem_rdata_valid = 1'b0;
      if_fx.req_start = '0; if_fx.req_write = '0;
      if_fx.req_wdata = '0; if_fx.req_wmask = '0;
      if_fx.mem_cmd_ready = 1'b0; if_fx.mem_rdata = '0; if_fx.mem_rdata_valid = 1'b0;
   endtask

   // Holds requests high during reset to prove the outputs are forced low
   task automatic do_reset(input string tag);
      rst = 1'b1;
      clr_inputs();
      if_rr.req_start = '1;
      if_rr.mem_cmd_ready = 1'b1;
      if_rr.mem_rdata_valid = 1'b1;
      @(negedge clk);
      chk({tag, " rst start"}, 64'(if_rr.mem_cmd_start), 64'd0);
      chk({tag, " rst ready"}, 64'(if_rr.req_ready), 64'd0);
      chk({tag, " rst resp"}, 64'(if_rr.resp_valid), 64'd0);
      clr_inputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // start  write  rdy   rv    e_ready e_start e_write e_addr  e_resp
      tbl[0]  = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h10, 2'b00};
      tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h10, 2'b00};
      tbl[2]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h20, 2'b00};
      tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h00, 2'b00};
      tbl[4]  = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 32'h20, 2'b01};
      tbl[5]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h10, 2'b10};
      tbl[6]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00, 2'b01};
      tbl[7]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00, 2'b00};
      tbl[8]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h10, 2'b00};
      tbl[9]  = '{2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h10, 2'b00};
      tbl[10] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h10, 2'b00};
      tbl[11] = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 32'h20, 2'b00};

      if_rr.req_addr = '0;
      if_fx.req_addr = '0;
      do_reset("init");
      chk("init start", 64'(if_rr.mem_cmd_start), 64'd0);
      chk("init addr", 64'(if_rr.mem_addr), 64'd0);
      chk("init resp", 64'(if_rr.resp_valid), 64'd0);

      // Fixed priority table
      if_fx.req_addr[0] = 32'h10;
      if_fx.req_addr[1] = 32'h20;
      for (int i = 0; i < 12; i++) begin
         if_fx.req_start       = tbl[i].start;
         if_fx.req_write       = tbl[i].write;
         if_fx.mem_cmd_ready   = tbl[i].rdy;
         if_fx.mem_rdata_valid = tbl[i].rv;
         if_fx.mem_rdata       = 32'h1000 + 32'(i);
         @(negedge clk);
         chk($sformatf("vec%0d ready", i), 64'(if_fx.req_ready), 64'(tbl[i].e_ready));
         chk($sformatf("vec%0d start", i), 64'(if_fx.mem_cmd_start), 64'(tbl[i].e_start));
         chk($sformatf("vec%0d write", i), 64'(if_fx.mem_cmd_write), 64'(tbl[i].e_write));
         chk($sformatf("vec%0d addr", i), 64'(if_fx.mem_addr), 64'(tbl[i].e_addr));
         chk($sformatf("vec%0d resp", i), 64'(if_fx.resp_valid), 64'(tbl[i].e_resp));
         chk($sformatf("vec%0d rdata", i), 64'(if_fx.resp_rdata),
             (tbl[i].e_resp != 2'b00) ? 64'(32'h1000 + 32'(i)) : 64'd0);
         tick();
      end
      clr_inputs();

      // Round-robin fairness with responses two cycles after issue
      do_reset("rr");
      if_rr.req_addr[0] = 32'h100;
      if_rr.req_addr[1] = 32'h200;
      if_rr.req_addr[2] = 32'h300;
      for (int k = 0; k < 8; k++) begin
         if_rr.req_start       = (k < 6) ? 3'b111 : 3'b000;
         if_rr.req_write       = 3'b000;
         if_rr.mem_cmd_ready   = 1'b1;
         if_rr.mem_rdata_valid = (k >= 2);
         if_rr.mem_rdata       = 32'hA000 + 32'(k);
         @(negedge clk);
         if (k < 6) begin
            chk($sformatf("rr%0d ready", k), 64'(if_rr.req_ready), 64'(3'b001 << (k % 3)));
            chk($sformatf("rr%0d addr", k), 64'(if_rr.mem_addr), 64'(32'h100 * (k % 3 + 1)));
         end
         if (k >= 2) begin
            chk($sformatf("rr%0d resp", k), 64'(if_rr.resp_valid), 64'(3'b001 << ((k - 2) % 3)));
            chk($sformatf("rr%0d rdata", k), 64'(if_rr.resp_rdata), 64'(32'hA000 + 32'(k)));
         end
         tick();
      end
      clr_inputs();

      // Lock hold: stalled port 1 keeps the bus while port 0 arrives
      do_reset("lock");
      if_rr.req_addr[0] = 32'h200;
      if_rr.req_addr[1] = 32'h100;
      for (int c = 0; c < 5; c++) begin
         if_rr.req_start     = (c == 0) ? 3'b010 : (c == 4) ? 3'b001 : 3'b011;
         if_rr.req_write     = 3'b000;
         if_rr.mem_cmd_ready = (c >= 3);
         @(negedge clk);
         chk($sformatf("lock%0d addr", c), 64'(if_rr.mem_addr), (c == 4) ? 64'h200 : 64'h100);
         chk($sformatf("lock%0d ready", c), 64'(if_rr.req_ready),
             (c == 3) ? 64'd2 : (c == 4) ? 64'd1 : 64'd0);
         tick();
      end
      clr_inputs();

      // FIFO full: reads stall, writes pass, first response frees a slot
      do_reset("full");
      if_rr.req_addr[0] = 32'h40;
      if_rr.req_addr[1] = 32'h80;
      if_rr.mem_cmd_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if_rr.req_start       = (c == 4) ? 3'b011 : 3'b001;
         if_rr.req_write       = 3'b010;
         if_rr.mem_rdata_valid = (c == 6);
         if_rr.mem_rdata       = 32'h5555;
         @(negedge clk);
         chk($sformatf("full%0d ready", c), 64'(if_rr.req_ready),
             (c < 4 || c == 7) ? 64'd1 : (c == 4) ? 64'd2 : 64'd0);
         if (c == 4) chk("full4 write", 64'(if_rr.mem_cmd_write), 64'd1);
         if (c == 5) chk("full5 start", 64'(if_rr.mem_cmd_start), 64'd0);
         if (c == 6) chk("full6 resp", 64'(if_rr.resp_valid), 64'd1);
         tick();
      end
      clr_inputs();

      // Write command and read response in the same cycle
      do_reset("ovl");
      if_rr.mem_cmd_ready = 1'b1;
      if_rr.req_start = 3'b010;
      @(negedge clk);
      chk("ovl0 ready", 64'(if_rr.req_ready), 64'd2);
      tick();
      if_rr.req_start       = 3'b001;
      if_rr.req_write       = 3'b001;
      if_rr.req_wdata[0]    = 32'hDEADBEEF;
      if_rr.req_wmask[0]    = 32'hFFFF0000;
      if_rr.mem_rdata_valid = 1'b1;
      if_rr.mem_rdata       = 32'h12345678;
      @(negedge clk);
      chk("ovl1 wmask", 64'(if_rr.mem_wmask), 64'hFFFF0000);
      chk("ovl1 wdata", 64'(if_rr.mem_wdata), 64'hDEADBEEF);
      chk("ovl1 write", 64'(if_rr.mem_cmd_write), 64'd1);
      chk("ovl1 ready", 64'(if_rr.req_ready), 64'd1);
      chk("ovl1 resp", 64'(if_rr.resp_valid), 64'd2);
      chk("ovl1 rdata", 64'(if_rr.resp_rdata), 64'h12345678);
      tick();
      clr_inputs();

      // Reset with two reads outstanding: later responses are stray
      do_reset("mid");
      if_rr.mem_cmd_ready = 1'b1;
      if_rr.req_start = 3'b101;
      @(negedge clk);
      chk("mid0 ready", 64'(if_rr.req_ready), 64'd1);
      tick();
      @(negedge clk);
      chk("mid1 ready", 64'(if_rr.req_ready), 64'd4);
      tick();
      do_reset("mid");
      if_rr.mem_rdata_valid = 1'b1;
      if_rr.mem_rdata = 32'hBAD0;
      @(negedge clk);
      chk("mid stray resp", 64'(if_rr.resp_valid), 64'd0);
      chk("mid stray rdata", 64'(if_rr.resp_rdata), 64'd0);
      chk("mid stray start", 64'(if_rr.mem_cmd_start), 64'd0);
      tick();
      clr_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
